// File: rtl/kiwi_pkg.sv
// Shared kiwi definitions: scoreboard id width and branch function codes.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package kiwi_pkg;

  localparam int unsigned SidWidth = `SCOREBOARD_SIZE_WIDTH + 1;

  localparam logic [3:0] FuncJal  = 4'b0111;
  localparam logic [3:0] FuncJalr = 4'b0101;
  localparam logic [3:0] FuncB    = 4'b0100;

endpackage

// File: rtl/brq_entry.sv
// One branch issue queue slot: payload, per-operand ready/tag/value and writeback tag compare.
// BRQ_WAKEUP_ISSUE_EN exposes a same-cycle wakeup as ready with the writeback value forwarded.
module brq_entry
  import kiwi_pkg::*;
#(
  parameter int unsigned SID_W = kiwi_pkg::SidWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic                  pop_i,
  input  logic [63:0]           pc_i,
  input  logic [31:0]           inst_i,
  input  logic [SID_W-1:0]      sid_i,
  input  logic [3:0]            func_i,
  input  logic [1:0]            rs_ready_i,
  input  logic [1:0][SID_W-1:0] rs_tag_i,
  input  logic [1:0][63:0]      rs_value_i,
  input  logic                  wb_valid_i,
  input  logic [SID_W-1:0]      wb_sid_i,
  input  logic [63:0]           wb_value_i,
  output logic                  valid_o,
  output logic [63:0]           pc_o,
  output logic [31:0]           inst_o,
  output logic [SID_W-1:0]      sid_o,
  output logic [3:0]            func_o,
  output logic [1:0]            issue_ready_o,
  output logic [1:0][63:0]      issue_value_o
);

  logic [1:0]            ready_q;
  logic [1:0][SID_W-1:0] tag_q;
  logic [1:0][63:0]      value_q;
  logic [1:0]            wr_hit;
  logic [1:0]            wake;

  always_comb begin
    wr_hit = '0;
    wake   = '0;
    for (int i = 0; i < 2; i++) begin
      wr_hit[i] = wb_valid_i & ~rs_ready_i[i] & (wb_sid_i == rs_tag_i[i]);
      wake[i]   = valid_o & ~ready_q[i] & wb_valid_i & (wb_sid_i == tag_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      inst_o  <= '0;
      sid_o   <= '0;
      func_o  <= '0;
      ready_q <= '0;
      tag_q   <= '0;
      value_q <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      ready_q <= '0;
    end else if (wr_en_i) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      inst_o  <= inst_i;
      sid_o   <= sid_i;
      func_o  <= func_i;
      tag_q   <= rs_tag_i;
      for (int i = 0; i < 2; i++) begin
        ready_q[i] <= rs_ready_i[i] | wr_hit[i];
        value_q[i] <= wr_hit[i] ? wb_value_i : rs_value_i[i];
      end
    end else begin
      if (pop_i) valid_o <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (wake[i]) begin
          ready_q[i] <= 1'b1;
          value_q[i] <= wb_value_i;
        end
      end
    end
  end

`ifdef BRQ_WAKEUP_ISSUE_EN
  always_comb begin
    issue_ready_o = '0;
    issue_value_o = '0;
    for (int i = 0; i < 2; i++) begin
      issue_ready_o[i] = ready_q[i] | wake[i];
      issue_value_o[i] = wake[i] ? wb_value_i : value_q[i];
    end
  end
`else
  assign issue_ready_o = ready_q;
  assign issue_value_o = value_q;
`endif

endmodule

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue: issues the head once both operands are ready, registered outputs.
// Define BRQ_WAKEUP_ISSUE_EN to let the head issue in the same cycle as its final wakeup.
module branch_issue_queue
  import kiwi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SID_W = kiwi_pkg::SidWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [63:0]      enq_pc_i,
  input  logic [31:0]      enq_inst_i,
  input  logic [SID_W-1:0] enq_sid_i,
  input  logic [3:0]       enq_func_code_i,
  input  logic             enq_rs1_ready_i,
  input  logic [SID_W-1:0] enq_rs1_tag_i,
  input  logic [63:0]      enq_rs1_value_i,
  input  logic             enq_rs2_ready_i,
  input  logic [SID_W-1:0] enq_rs2_tag_i,
  input  logic [63:0]      enq_rs2_value_i,
  input  logic             wb_valid_i,
  input  logic [SID_W-1:0] wb_sid_i,
  input  logic [63:0]      wb_value_i,
  output logic             branch_valid_o,
  output logic [63:0]      branch_pc_o,
  output logic [31:0]      branch_inst_o,
  output logic [SID_W-1:0] branch_sid_o,
  output logic [63:0]      rs1_value_o,
  output logic [63:0]      rs2_value_o,
  output logic [3:0]       func_code_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;

  logic                 e_valid [DEPTH];
  logic [63:0]          e_pc    [DEPTH];
  logic [31:0]          e_inst  [DEPTH];
  logic [SID_W-1:0]     e_sid   [DEPTH];
  logic [3:0]           e_func  [DEPTH];
  logic [1:0]           e_ready [DEPTH];
  logic [1:0][63:0]     e_value [DEPTH];

  logic                  enq_fire, push, bypass, issue_head;
  logic [1:0]            enq_rdy, bypass_rdy;
  logic [1:0][SID_W-1:0] enq_tag;
  logic [1:0][63:0]      enq_value, bypass_value;

  assign enq_rdy   = {enq_rs2_ready_i, enq_rs1_ready_i};
  assign enq_tag   = {enq_rs2_tag_i, enq_rs1_tag_i};
  assign enq_value = {enq_rs2_value_i, enq_rs1_value_i};

`ifdef BRQ_WAKEUP_ISSUE_EN
  always_comb begin
    bypass_rdy   = enq_rdy;
    bypass_value = enq_value;
    for (int i = 0; i < 2; i++) begin
      if (wb_valid_i && !enq_rdy[i] && wb_sid_i == enq_tag[i]) begin
        bypass_rdy[i]   = 1'b1;
        bypass_value[i] = wb_value_i;
      end
    end
  end
`else
  assign bypass_rdy   = enq_rdy;
  assign bypass_value = enq_value;
`endif

  assign enq_ready_o = (count_q < Full) & ~flush_i;
  assign enq_fire    = enq_valid_i & enq_ready_o;
  assign issue_head  = e_valid[head_q] & (&e_ready[head_q]) & ~flush_i;
  // An empty queue hands a fully-ready branch straight to the outputs for 1-cycle latency.
  assign bypass      = ~e_valid[head_q] & enq_fire & (&bypass_rdy);
  assign push        = enq_fire & ~bypass;

  for (genvar g = 0; g < DEPTH; g++) begin : gen_entry
    brq_entry #(
      .SID_W(SID_W)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .wr_en_i      (push && tail_q == PtrW'(g)),
      .pop_i        (issue_head && head_q == PtrW'(g)),
      .pc_i         (enq_pc_i),
      .inst_i       (enq_inst_i),
      .sid_i        (enq_sid_i),
      .func_i       (enq_func_code_i),
      .rs_ready_i   (enq_rdy),
      .rs_tag_i     (enq_tag),
      .rs_value_i   (enq_value),
      .wb_valid_i   (wb_valid_i),
      .wb_sid_i     (wb_sid_i),
      .wb_value_i   (wb_value_i),
      .valid_o      (e_valid[g]),
      .pc_o         (e_pc[g]),
      .inst_o       (e_inst[g]),
      .sid_o        (e_sid[g]),
      .func_o       (e_func[g]),
      .issue_ready_o(e_ready[g]),
      .issue_value_o(e_value[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (issue_head) head_q <= head_q + 1'b1;
      if (push)       tail_q <= tail_q + 1'b1;
      unique case ({push, issue_head})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic [63:0]      sel_pc, sel_rs1, sel_rs2;
  logic [31:0]      sel_inst;
  logic [SID_W-1:0] sel_sid;
  logic [3:0]       sel_func;

  always_comb begin
    sel_pc   = enq_pc_i;
    sel_inst = enq_inst_i;
    sel_sid  = enq_sid_i;
    sel_func = enq_func_code_i;
    sel_rs1  = bypass_value[0];
    sel_rs2  = bypass_value[1];
    if (issue_head) begin
      sel_pc   = e_pc[head_q];
      sel_inst = e_inst[head_q];
      sel_sid  = e_sid[head_q];
      sel_func = e_func[head_q];
      sel_rs1  = e_value[head_q][0];
      sel_rs2  = e_value[head_q][1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_valid_o <= 1'b0;
      branch_pc_o    <= '0;
      branch_inst_o  <= '0;
      branch_sid_o   <= '0;
      func_code_o    <= '0;
      rs1_value_o    <= '0;
      rs2_value_o    <= '0;
    end else begin
      branch_valid_o <= issue_head | bypass;
      if (issue_head || bypass) begin
        branch_pc_o   <= sel_pc;
        branch_inst_o <= sel_inst;
        branch_sid_o  <= sel_sid;
        func_code_o   <= sel_func;
        rs1_value_o   <= sel_rs1;
        rs2_value_o   <= sel_rs2;
      end
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Scoreboard bench for branch_issue_queue: directed scenarios then random traffic vs a queue model.
module tb_branch_issue_queue;
  import kiwi_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = kiwi_pkg::SidWidth;
`ifdef BRQ_WAKEUP_ISSUE_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i, enq_valid_i, enq_ready_o;
  logic [63:0] enq_pc_i, enq_rs1_value_i, enq_rs2_value_i, wb_value_i;
  logic [31:0] enq_inst_i;
  logic [SW-1:0] enq_sid_i, enq_rs1_tag_i, enq_rs2_tag_i, wb_sid_i;
  logic [3:0] enq_func_code_i;
  logic enq_rs1_ready_i, enq_rs2_ready_i, wb_valid_i;
  logic branch_valid_o;
  logic [63:0] branch_pc_o, rs1_value_o, rs2_value_o;
  logic [31:0] branch_inst_o;
  logic [SW-1:0] branch_sid_o;
  logic [3:0] func_code_o;

  branch_issue_queue #(.DEPTH(DEPTH), .SID_W(SW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i), .enq_sid_i(enq_sid_i),
    .enq_func_code_i(enq_func_code_i),
    .enq_rs1_ready_i(enq_rs1_ready_i), .enq_rs1_tag_i(enq_rs1_tag_i),
    .enq_rs1_value_i(enq_rs1_value_i),
    .enq_rs2_ready_i(enq_rs2_ready_i), .enq_rs2_tag_i(enq_rs2_tag_i),
    .enq_rs2_value_i(enq_rs2_value_i),
    .wb_valid_i(wb_valid_i), .wb_sid_i(wb_sid_i), .wb_value_i(wb_value_i),
    .branch_valid_o(branch_valid_o), .branch_pc_o(branch_pc_o),
    .branch_inst_o(branch_inst_o), .branch_sid_o(branch_sid_o),
    .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o), .func_code_o(func_code_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc; logic [31:0] inst; logic [SW-1:0] sid; logic [3:0] func;
    bit r1; logic [SW-1:0] t1; logic [63:0] v1;
    bit r2; logic [SW-1:0] t2; logic [63:0] v2;
  } br_t;

  typedef struct {
    int cyc; logic [63:0] pc; logic [31:0] inst; logic [SW-1:0] sid; logic [3:0] func;
    logic [63:0] v1; logic [63:0] v2;
  } exp_t;

  br_t  mq[$];
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Stimulus for the next cycle, applied by step().
  bit s_enq, s_r1, s_r2, s_wb, s_flush;
  logic [63:0] s_pc, s_v1, s_v2, s_wval;
  logic [31:0] s_inst;
  logic [SW-1:0] s_sid, s_t1, s_t2, s_wsid;
  logic [3:0] s_func;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit hit(input logic [SW-1:0] t);
    return s_wb && s_wsid == t;
  endfunction

  task automatic clr();
    s_enq = 0; s_r1 = 1; s_r2 = 1; s_wb = 0; s_flush = 0;
    s_pc = '0; s_v1 = '0; s_v2 = '0; s_wval = '0; s_inst = '0;
    s_sid = '0; s_t1 = '0; s_t2 = '0; s_wsid = '0; s_func = FuncB;
  endtask

  task automatic drive_idle();
    flush_i = 0; enq_valid_i = 0; wb_valid_i = 0;
    enq_pc_i = '0; enq_inst_i = '0; enq_sid_i = '0; enq_func_code_i = '0;
    enq_rs1_ready_i = 0; enq_rs1_tag_i = '0; enq_rs1_value_i = '0;
    enq_rs2_ready_i = 0; enq_rs2_tag_i = '0; enq_rs2_value_i = '0;
    wb_sid_i = '0; wb_value_i = '0;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] inst,
                          input logic [SW-1:0] sid, input logic [3:0] func,
                          input logic [63:0] v1, input logic [63:0] v2);
    exp_t x;
    x.cyc = cyc + 1; x.pc = pc; x.inst = inst; x.sid = sid; x.func = func;
    x.v1 = v1; x.v2 = v2;
    sb.push_back(x);
  endtask

  // One cycle: apply stimulus, check enq_ready, advance the queue model.
  task automatic step();
    bit acc, was_empty, issued;
    br_t h, n;
    @(posedge clk); #1;
    flush_i = s_flush; enq_valid_i = s_enq; wb_valid_i = s_wb;
    enq_pc_i = s_pc; enq_inst_i = s_inst; enq_sid_i = s_sid; enq_func_code_i = s_func;
    enq_rs1_ready_i = s_r1; enq_rs1_tag_i = s_t1; enq_rs1_value_i = s_v1;
    enq_rs2_ready_i = s_r2; enq_rs2_tag_i = s_t2; enq_rs2_value_i = s_v2;
    wb_sid_i = s_wsid; wb_value_i = s_wval;
    #1;
    chk("enq_ready", enq_ready_o, 64'(!s_flush && mq.size() < DEPTH));
    if (s_flush) begin
      mq.delete();
      return;
    end
    acc = s_enq && mq.size() < DEPTH;
    was_empty = mq.size() == 0;
    issued = 0;
    if (!was_empty) begin
      h = mq[0];
      if ((h.r1 || (FEAT && hit(h.t1))) && (h.r2 || (FEAT && hit(h.t2)))) begin
        push_exp(h.pc, h.inst, h.sid, h.func, h.r1 ? h.v1 : s_wval, h.r2 ? h.v2 : s_wval);
        issued = 1;
      end
    end
    foreach (mq[i]) begin
      if (!mq[i].r1 && hit(mq[i].t1)) begin mq[i].r1 = 1; mq[i].v1 = s_wval; end
      if (!mq[i].r2 && hit(mq[i].t2)) begin mq[i].r2 = 1; mq[i].v2 = s_wval; end
    end
    if (issued) void'(mq.pop_front());
    if (acc) begin
      n.pc = s_pc; n.inst = s_inst; n.sid = s_sid; n.func = s_func;
      n.r1 = s_r1; n.t1 = s_t1; n.v1 = s_v1; n.r2 = s_r2; n.t2 = s_t2; n.v2 = s_v2;
      if (!n.r1 && hit(n.t1)) begin n.r1 = 1; n.v1 = s_wval; end
      if (!n.r2 && hit(n.t2)) begin n.r2 = 1; n.v2 = s_wval; end
      if (was_empty && (s_r1 || (FEAT && hit(s_t1))) && (s_r2 || (FEAT && hit(s_t2))))
        push_exp(n.pc, n.inst, n.sid, n.func, n.v1, n.v2);
      else
        mq.push_back(n);
    end
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) step();
  endtask

  task automatic enq(input logic [63:0] pc, input bit r1, input logic [SW-1:0] t1,
                     input bit r2, input logic [SW-1:0] t2);
    clr();
    s_enq = 1; s_pc = pc; s_inst = 32'h63 ^ pc[31:0]; s_sid = SW'(pc[5:2]);
    s_r1 = r1; s_t1 = t1; s_v1 = 64'hA000 + pc;
    s_r2 = r2; s_t2 = t2; s_v2 = 64'hB000 + pc;
    step();
  endtask

  task automatic wb(input logic [SW-1:0] sid, input logic [63:0] val);
    clr();
    s_wb = 1; s_wsid = sid; s_wval = val;
    step();
  endtask

  // Asserts reset (already high at time 0, or mid-stream) and checks the reset state.
  task automatic do_reset(input bool_mid);
    if (bool_mid) begin
      @(posedge clk); #1;
    end
    rst = 1;
    drive_idle();
    sb.delete();
    mq.delete();
    #1;
    chk("rst_valid", branch_valid_o, 0);
    chk("rst_pc", branch_pc_o, 0);
    chk("rst_inst", branch_inst_o, 0);
    chk("rst_sid", branch_sid_o, 0);
    chk("rst_func", func_code_o, 0);
    chk("rst_rs1", rs1_value_o, 0);
    chk("rst_rs2", rs2_value_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 0;
    #1;
    chk("enq_ready_after_rst", enq_ready_o, 1);
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (branch_valid_o) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_issue: got valid pc=%h want no issue (cycle %0d)",
                   branch_pc_o, cyc);
        end else begin
          e = sb.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("issue_pc", branch_pc_o, e.pc);
          chk("issue_inst", 64'(branch_inst_o), 64'(e.inst));
          chk("issue_sid", 64'(branch_sid_o), 64'(e.sid));
          chk("issue_func", 64'(func_code_o), 64'(e.func));
          chk("issue_rs1", rs1_value_o, e.v1);
          chk("issue_rs2", rs2_value_o, e.v2);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        total++; bad++;
        $display("FAIL missing_issue: got no valid want pc=%h (cycle %0d)", sb[0].pc, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    clr();
    do_reset(1'b0);

    // Fully-ready branch into an empty queue issues on the next cycle.
    enq(64'h1000, 1, '0, 1, '0);
    idle(2);

    // rs1 waits on tag 5, woken two cycles later with 0x2A.
    enq(64'h2000, 0, SW'(5), 1, '0);
    idle(1);
    wb(SW'(5), 64'h2A);
    idle(3);

    // Fill with a blocked head, attempt a fifth enqueue, then release in order.
    enq(64'h0, 0, SW'(9), 1, '0);
    enq(64'h4, 1, '0, 1, '0);
    enq(64'h8, 1, '0, 1, '0);
    enq(64'hC, 1, '0, 1, '0);
    enq(64'h10, 1, '0, 1, '0);
    wb(SW'(9), 64'h99);
    idle(6);

    // Enqueue-time capture of a matching writeback.
    clr();
    s_enq = 1; s_pc = 64'h3000; s_r1 = 0; s_t1 = SW'(3); s_v1 = 64'hDEAD;
    s_wb = 1; s_wsid = SW'(3); s_wval = 64'h7;
    step();
    idle(3);

    // Flush together with an enqueue drops everything.
    enq(64'h4000, 0, SW'(11), 1, '0);
    enq(64'h4004, 1, '0, 1, '0);
    enq(64'h4008, 1, '0, 1, '0);
    clr();
    s_flush = 1; s_enq = 1; s_pc = 64'h400C;
    step();
    enq(64'h5000, 0, SW'(12), 1, '0);
    wb(SW'(11), 64'h11);
    idle(3);
    clr(); s_flush = 1; step();
    idle(2);

    // Reset mid-stream with two queued entries.
    enq(64'h6000, 0, SW'(13), 1, '0);
    enq(64'h6004, 1, '0, 1, '0);
    do_reset(1'b1);
    enq(64'h7000, 1, '0, 1, '0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      clr();
      s_enq = $urandom_range(0, 9) < 6;
      s_pc = {$urandom, $urandom};
      s_inst = $urandom;
      s_sid = SW'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: s_func = FuncB;
        1: s_func = FuncJal;
        default: s_func = FuncJalr;
      endcase
      s_r1 = $urandom_range(0, 1); s_t1 = SW'($urandom_range(0, 7)); s_v1 = {$urandom, $urandom};
      s_r2 = $urandom_range(0, 1); s_t2 = SW'($urandom_range(0, 7)); s_v2 = {$urandom, $urandom};
      s_wb = $urandom_range(0, 9) < 4;
      s_wsid = SW'($urandom_range(0, 7));
      s_wval = {$urandom, $urandom};
      s_flush = $urandom_range(0, 49) == 0;
      step();
    end

    clr(); s_flush = 1; step();
    idle(3);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_issue_queue.md
BRANCH_ISSUE_QUEUE -- requirements
Module: branch_issue_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning number of queue entries; power of two, 2..16.
REQ-002 SHALL provide parameter SID_W, default `SCOREBOARD_SIZE_WIDTH+1, meaning width of all scoreboard id and tag ports.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  pipeline flush.
REQ-006 SHALL have ports enq_valid_i  input  1 and enq_ready_o  output  1  enqueue handshake.
REQ-007 SHALL have ports enq_pc_i  input  64, enq_inst_i  input  32, enq_sid_i  input  SID_W and enq_func_code_i  input  4  branch payload.
REQ-008 SHALL have ports enq_rs1_ready_i  input  1, enq_rs1_tag_i  input  SID_W and enq_rs1_value_i  input  64  rs1 operand status, producer tag and value; rs2 has an identical triple.
REQ-009 SHALL have ports wb_valid_i  input  1, wb_sid_i  input  SID_W and wb_value_i  input  64  writeback broadcast.
REQ-010 SHALL have ports branch_valid_o  output  1, branch_pc_o  output  64, branch_inst_o  output  32, branch_sid_o  output  SID_W, rs1_value_o  output  64, rs2_value_o  output  64 and func_code_o  output  4  issue to the branch execution unit.

Function
REQ-011 SHALL be an in-order circular FIFO: head/tail pointers log2(DEPTH) bits wrapping mod DEPTH, plus an occupancy count 0..DEPTH.
REQ-012 SHALL drive enq_ready_o = (count < DEPTH) & ~flush_i, with no pop-through when full.
REQ-013 SHALL write the tail entry on enq_valid_i & enq_ready_o, storing the payload plus per-operand ready, tag and value.
REQ-014 SHALL, on wb_valid_i with wb_sid_i equal to a stored not-ready operand tag, set that operand ready and capture wb_value_i at the next edge; all matching entries update in parallel.
REQ-015 SHALL, on enqueue of a not-ready operand whose tag equals wb_sid_i while wb_valid_i is high, store that operand as ready with wb_value_i.
REQ-016 SHALL issue only the head entry, and only when both its operands are ready; younger ready entries never bypass it.
REQ-017 SHALL register all outputs: on issue, the branch_* outputs load the head payload and branch_valid_o=1 for exactly one cycle, and the head pops.
REQ-018 SHALL make a minimum latency of 1 cycle from enqueue of a fully-ready branch into an empty queue to branch_valid_o.
REQ-019 SHALL permit enqueue and issue in the same cycle, leaving count unchanged.
REQ-020 SHALL make flush_i dominant: at the next edge all entries are invalid, count=0, pointers=0 and branch_valid_o=0; a same-cycle enqueue, issue or wakeup is discarded.

Reset
REQ-021 SHALL, while rst is high, hold count=0, pointers=0, all entry valid/ready bits=0, branch_valid_o=0 and all other outputs 0.
REQ-022 SHALL drive enq_ready_o=1 in the first cycle after rst deasserts.
REQ-023 SHALL, on rst asserted mid-operation, lose all queued branches without issuing them.

Configuration
REQ-024 SHALL support macro BRQ_WAKEUP_ISSUE_EN.
REQ-025 SHALL, when BRQ_WAKEUP_ISSUE_EN is defined, allow a head entry whose last missing operand matches the current writeback to issue in that same cycle, with wb_value_i forwarded to rs*_value_o (wakeup-to-valid 1 cycle).
REQ-026 SHALL, when BRQ_WAKEUP_ISSUE_EN is undefined, have the head issue no earlier than the cycle after the wakeup is captured (wakeup-to-valid 2 cycles).

Structure
REQ-027 SHALL take func-code constants (JAL 4'b0111, JALR 4'b0101, B 4'b0100) and the SID width from the shared kiwi package.
REQ-028 SHALL implement per-entry operand storage and tag compare in one sub-module, brq_entry, instantiated DEPTH times.

Verification
REQ-029 SHALL cover: empty queue, enqueue pc=0x1000 with both operands ready -> branch_valid_o=1 next cycle with pc=0x1000 and count back to 0.
REQ-030 SHALL cover: enqueue rs1 tag=5 not ready, then wb_sid_i=5 with value 0x2A two cycles later -> rs1_value_o=0x2A, valid 1 cycle after wb with BRQ_WAKEUP_ISSUE_EN defined and 2 cycles after without it.
REQ-031 SHALL cover: four enqueues with head blocked -> enq_ready_o=0; a fifth enqueue attempt is not accepted; releasing the head issues in order pc 0x0,0x4,0x8,0xC.
REQ-032 SHALL cover: enqueue with tag=3 in the same cycle as wb_sid_i=3 (value 0x7) -> operand captured, issue carries 0x7.
REQ-033 SHALL cover: three entries queued, flush_i pulsed together with an enqueue -> count=0 next cycle and no branch_valid_o afterwards.
REQ-034 SHALL cover: rst asserted mid-stream with 2 entries -> all outputs 0 immediately, enq_ready_o=1 after release.
